// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256_core among NUM_REQ requesters, with a chaining lock.
// Define SHA_ARB_LOCK_TIMEOUT_EN to build the forced lock release after LOCK_TIMEOUT idle cycles.
module sha256_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_init,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*512-1:0] req_message,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ-1:0]     resp_done,
  output logic [255:0]           resp_hash,
  output logic [NUM_REQ-1:0]     lock_abort,
  output logic                   busy,
  output logic                   core_start,
  output logic                   core_init,
  output logic [511:0]           core_message,
  input  logic                   core_ready,
  input  logic                   core_valid,
  input  logic [255:0]           core_hash
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CW    = IDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, LOCKED} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr, owner, winner, grant_idx, next_ptr;
  logic [CW-1:0]      cand;
  logic               found, grant_go, last_q;
  logic [NUM_REQ-1:0] grant_1h, owner_1h;
  logic [511:0]       grant_msg;

`ifdef SHA_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] lock_cnt;
`endif

  // Scan downward so the surviving hit is the one closest to rr_ptr.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + CW'(i);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (req_valid[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    grant_idx = (state == LOCKED) ? owner : winner;
    grant_go  = core_ready && (((state == IDLE) && found) ||
                               ((state == LOCKED) && req_valid[owner]));
    grant_msg = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) grant_msg = req_message[i*512 +: 512];
    end
  end

  assign next_ptr = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
  assign grant_1h = NUM_REQ'(1) << grant_idx;
  assign owner_1h = NUM_REQ'(1) << owner;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      last_q       <= 1'b0;
      req_ack      <= '0;
      resp_done    <= '0;
      resp_hash    <= '0;
      lock_abort   <= '0;
      core_start   <= 1'b0;
      core_init    <= 1'b0;
      core_message <= '0;
`ifdef SHA_ARB_LOCK_TIMEOUT_EN
      lock_cnt     <= '0;
`endif
    end else begin
      req_ack    <= '0;
      resp_done  <= '0;
      resp_hash  <= '0;
      lock_abort <= '0;
      core_start <= 1'b0;
      core_init  <= 1'b0;
      if (grant_go) begin
        state        <= ISSUE;
        owner        <= grant_idx;
        last_q       <= req_last[grant_idx];
        core_message <= grant_msg;
        core_start   <= 1'b1;
        core_init    <= req_init[grant_idx];
        req_ack      <= grant_1h;
        if (state == IDLE) rr_ptr <= next_ptr;
`ifdef SHA_ARB_LOCK_TIMEOUT_EN
        lock_cnt     <= '0;
`endif
      end else begin
        case (state)
          ISSUE: state <= BUSY;
          // The block is consumed, so the plaintext is wiped as the digest goes out.
          BUSY: begin
            if (core_valid) begin
              resp_hash    <= core_hash;
              resp_done    <= owner_1h;
              core_message <= '0;
              state        <= last_q ? IDLE : LOCKED;
            end
          end
          LOCKED: begin
`ifdef SHA_ARB_LOCK_TIMEOUT_EN
            if (!req_valid[owner]) begin
              if (lock_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                state      <= IDLE;
                lock_abort <= owner_1h;
                lock_cnt   <= '0;
              end else begin
                lock_cnt <= lock_cnt + CNT_W'(1);
              end
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: directed timing scenarios plus randomized traffic checked
// against a transaction-level model of grants, locks and digests.
`timescale 1ns/1ps
module tb_sha256_arbiter;
  localparam int N       = 3;
  localparam int TIMEOUT = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_init, req_last;
  logic [N*512-1:0] req_message;
  logic [N-1:0]   req_ack, resp_done, lock_abort;
  logic [255:0]   resp_hash, core_hash;
  logic           busy, core_start, core_init, core_ready, core_valid;
  logic [511:0]   core_message;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // behavioural core
  bit           core_busy, core_stall, core_manual, use_fixed;
  int           core_cnt;
  int           core_lat = 4;
  logic [511:0] cap_msg;
  logic         cap_init;
  logic [255:0] fixed_hash;

  // scenario scratch
  int           order[$];
  int           seq_idx[$];
  logic         seq_init[$];
  logic [511:0] seq_msg[$];
  logic [511:0] msg_a, msg_b, msg_c;
  int           early, bad_done, bad_hash, bad_msg, bad_start, done2_cnt, b_delay;
  int           lock_cyc, ab_cyc, ack_cyc;
  logic [N-1:0] ab_vec, ack_vec;

  // reference model state
  bit           lock_v, outst, outst_last;
  int           lock_o, outst_o, rr, w, j, exp_owner;
  logic [N-1:0] exp_ack, exp_done;
  logic         exp_init, exp_last_n;
  logic [511:0] exp_msg;
  logic [255:0] exp_hash, outst_hash;
  int           delay[N];
  int           blocks_left[N];

  sha256_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_init(req_init), .req_last(req_last),
    .req_message(req_message), .req_ack(req_ack), .resp_done(resp_done),
    .resp_hash(resp_hash), .lock_abort(lock_abort), .busy(busy),
    .core_start(core_start), .core_init(core_init), .core_message(core_message),
    .core_ready(core_ready), .core_valid(core_valid), .core_hash(core_hash)
  );

  always #5 clock = ~clock;

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [255:0] ref_hash(input logic [511:0] m, input logic i);
    return m[511:256] ^ m[255:0] ^ {255'b0, i} ^ 256'h5A;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    cyc++;
  endtask

  task automatic core_step();
    if (core_manual) return;
    core_valid = 1'b0;
    core_hash  = '0;
    if (core_busy) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_valid = 1'b1;
        core_hash  = use_fixed ? fixed_hash : ref_hash(cap_msg, cap_init);
        core_busy  = 1'b0;
      end
    end else if (core_start) begin
      core_busy = 1'b1;
      core_cnt  = core_lat;
      cap_msg   = core_message;
      cap_init  = core_init;
    end
    core_ready = !core_busy && !core_stall;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req_valid = '0; req_init = '0; req_last = '0; req_message = '0;
    core_busy = 1'b0; core_stall = 1'b0; core_manual = 1'b0; use_fixed = 1'b0;
    core_valid = 1'b0; core_hash = '0; core_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    cyc = 0;
  endtask

  // Random requester behaviour: multi-block messages, short gaps, drop valid on ack.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (req_ack[i]) begin
        req_valid[i] = 1'b0;
        blocks_left[i]--;
        delay[i] = (blocks_left[i] > 0) ? $urandom_range(0, 3) : $urandom_range(0, 6);
      end else if (!req_valid[i]) begin
        if (delay[i] > 0) delay[i]--;
        else begin
          req_init[i] = 1'b0;
          if (blocks_left[i] == 0) begin
            blocks_left[i] = $urandom_range(1, 3);
            req_init[i] = 1'b1;
          end
          req_last[i] = (blocks_left[i] == 1);
          req_message[i*512 +: 512] = rand512();
          req_valid[i] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    // reset state
    apply_reset();
    checkOutput("rst_ack", req_ack, '0);
    checkOutput("rst_done", resp_done, '0);
    checkOutput("rst_hash", resp_hash, '0);
    checkOutput("rst_abort", lock_abort, '0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_start", core_start, 1'b0);
    checkOutput("rst_msg", core_message, '0);

    // single request, core latency 64
    core_lat = 64; use_fixed = 1'b1; fixed_hash = {32{8'hAA}};
    req_valid = 3'b010; req_init = 3'b010; req_last = 3'b010;
    req_message[512 +: 512] = rand512();
    tick();
    checkOutput("single_ack", req_ack, 3'b010);
    checkOutput("single_start", core_start, 1'b1);
    checkOutput("single_init", core_init, 1'b1);
    core_step();
    req_valid = '0;
    early = 0;
    while (cyc < 65) begin
      tick();
      if (resp_done != '0) early++;
      core_step();
    end
    tick();
    checkOutput("single_early_done", early, 0);
    checkOutput("single_done", resp_done, 3'b010);
    checkOutput("single_hash", resp_hash, {32{8'hAA}});
    core_step();
    tick();
    checkOutput("single_hash_clear", resp_hash, '0);
    checkOutput("single_idle", busy, 1'b0);

    // round-robin fairness
    apply_reset();
    core_lat = 3;
    req_valid = 3'b111; req_init = 3'b111; req_last = 3'b111;
    req_message = {rand512(), rand512(), rand512()};
    order.delete();
    for (int n = 0; n < 200 && order.size() < 6; n++) begin
      tick();
      for (int i = 0; i < N; i++) if (req_ack[i]) order.push_back(i);
      core_step();
    end
    checkOutput("rr_count", order.size(), 6);
    for (int k = 0; k < 6; k++)
      checkOutput($sformatf("rr_grant%0d", k), (k < order.size()) ? order[k] : -1, k % 3);

    // lock across a two-block message
    apply_reset();
    core_lat = 5;
    msg_a = rand512(); msg_b = rand512(); msg_c = rand512();
    req_valid = 3'b100; req_init = 3'b100; req_last = 3'b000;
    req_message[1024 +: 512] = msg_a;
    seq_idx.delete(); seq_init.delete(); seq_msg.delete();
    done2_cnt = 0; b_delay = -1;
    for (int n = 0; n < 300 && seq_idx.size() < 3; n++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_ack[i]) begin
          seq_idx.push_back(i); seq_init.push_back(core_init); seq_msg.push_back(core_message);
        end
      end
      if (resp_done[2]) done2_cnt++;
      core_step();
      if (req_ack[2]) req_valid[2] = 1'b0;
      if (req_ack[2] && seq_idx.size() == 1) begin
        req_valid[0] = 1'b1; req_init[0] = 1'b1; req_last[0] = 1'b1;
        req_message[0 +: 512] = msg_c;
      end
      if (req_ack[0]) req_valid[0] = 1'b0;
      if (resp_done[2] && done2_cnt == 1) b_delay = 3;
      if (b_delay > 0) begin
        b_delay--;
        if (b_delay == 0) begin
          req_valid[2] = 1'b1; req_init[2] = 1'b0; req_last[2] = 1'b1;
          req_message[1024 +: 512] = msg_b;
        end
      end
    end
    checkOutput("lock_count", seq_idx.size(), 3);
    if (seq_idx.size() == 3) begin
      checkOutput("lock_a_owner", seq_idx[0], 2);
      checkOutput("lock_b_owner", seq_idx[1], 2);
      checkOutput("lock_next_owner", seq_idx[2], 0);
      checkOutput("lock_a_init", seq_init[0], 1'b1);
      checkOutput("lock_b_init", seq_init[1], 1'b0);
      checkOutput("lock_a_msg", seq_msg[0], msg_a);
      checkOutput("lock_b_msg", seq_msg[1], msg_b);
    end

    // core not ready
    apply_reset();
    core_lat = 4; core_stall = 1'b1; core_ready = 1'b0;
    req_valid = 3'b001; req_init = 3'b001; req_last = 3'b001;
    req_message[0 +: 512] = rand512();
    bad_start = 0;
    repeat (10) begin
      tick();
      if (req_ack != '0 || core_start) bad_start++;
      core_step();
    end
    checkOutput("nrdy_quiet", bad_start, 0);
    core_stall = 1'b0; core_ready = 1'b1;
    tick();
    checkOutput("nrdy_ack", req_ack, 3'b001);
    checkOutput("nrdy_start", core_start, 1'b1);

    // reset while BUSY
    apply_reset();
    core_manual = 1'b1; core_ready = 1'b1; core_valid = 1'b0;
    req_valid = 3'b001; req_init = 3'b001; req_last = 3'b001;
    req_message[0 +: 512] = rand512();
    tick();
    checkOutput("rstbusy_ack", req_ack, 3'b001);
    req_valid = '0;
    tick();
    checkOutput("rstbusy_busy", busy, 1'b1);
    reset = 1'b1;
    bad_done = 0; bad_hash = 0; bad_msg = 0; bad_start = 0;
    for (int n = 0; n < 7; n++) begin
      tick();
      reset = 1'b0;
      if (resp_done != '0) bad_done++;
      if (resp_hash != '0) bad_hash++;
      if (core_message != '0) bad_msg++;
      if (core_start) bad_start++;
      core_valid = (cyc == 5);
      core_hash  = (cyc == 5) ? rand512() : '0;
    end
    checkOutput("rstbusy_no_done", bad_done, 0);
    checkOutput("rstbusy_no_hash", bad_hash, 0);
    checkOutput("rstbusy_msg_zero", bad_msg, 0);
    checkOutput("rstbusy_no_start", bad_start, 0);
    checkOutput("rstbusy_idle", busy, 1'b0);

    // owner goes silent in LOCKED
    apply_reset();
    core_lat = 4;
    req_valid = 3'b010; req_init = 3'b010; req_last = 3'b000;
    req_message[512 +: 512] = rand512();
    lock_cyc = -1;
    for (int n = 0; n < 200 && lock_cyc < 0; n++) begin
      tick();
      if (resp_done[1]) lock_cyc = cyc;
      core_step();
      if (req_ack[1]) begin
        req_valid = 3'b001; req_init = 3'b001; req_last = 3'b001;
        req_message[0 +: 512] = rand512();
      end
    end
    checkOutput("to_locked", lock_cyc >= 0, 1'b1);
    ab_cyc = -1; ack_cyc = -1; ab_vec = '0; ack_vec = '0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (lock_abort != '0 && ab_cyc < 0) begin ab_cyc = cyc; ab_vec = lock_abort; end
      if (req_ack != '0 && ack_cyc < 0) begin ack_cyc = cyc; ack_vec = req_ack; end
      core_step();
    end
`ifdef SHA_ARB_LOCK_TIMEOUT_EN
    checkOutput("to_abort_cycle", ab_cyc - lock_cyc, 8);
    checkOutput("to_abort_vec", ab_vec, 3'b010);
    checkOutput("to_ack_cycle", ack_cyc - lock_cyc, 9);
    checkOutput("to_ack_vec", ack_vec, 3'b001);
`else
    checkOutput("to_no_abort", ab_cyc, -1);
    checkOutput("to_no_ack", ack_cyc, -1);
`endif

    // randomized traffic against the transaction model
    apply_reset();
    lock_v = 1'b0; outst = 1'b0; outst_last = 1'b0; lock_o = 0; outst_o = 0; rr = 0;
    exp_ack = '0; exp_done = '0; exp_hash = '0; exp_init = 1'b0; exp_last_n = 1'b0;
    exp_msg = '0; exp_owner = 0; outst_hash = '0;
    for (int i = 0; i < N; i++) begin delay[i] = $urandom_range(0, 4); blocks_left[i] = 0; end
    for (int n = 0; n < 2000; n++) begin
      tick();
      checkOutput("rnd_ack", req_ack, exp_ack);
      checkOutput("rnd_start", core_start, exp_ack != '0);
      if (exp_ack != '0) begin
        checkOutput("rnd_init", core_init, exp_init);
        checkOutput("rnd_msg", core_message, exp_msg);
      end
      checkOutput("rnd_done", resp_done, exp_done);
      checkOutput("rnd_hash", resp_hash, exp_hash);
      checkOutput("rnd_abort", lock_abort, '0);
      if (exp_ack != '0) begin
        outst = 1'b1; outst_o = exp_owner; outst_last = exp_last_n;
        outst_hash = ref_hash(exp_msg, exp_init);
      end
      if (exp_done != '0) begin
        outst = 1'b0; lock_v = !outst_last; lock_o = outst_o;
      end
      checkOutput("rnd_busy", busy, outst || lock_v);
      core_stall = ($urandom_range(0, 7) == 0);
      core_lat   = $urandom_range(1, 6);
      core_step();
      exp_done = core_valid ? (N'(1) << outst_o) : '0;
      exp_hash = core_valid ? outst_hash : '0;
      applyStimulus();
      exp_ack = '0;
      w = -1;
      if (!outst && core_ready) begin
        if (lock_v) begin
          if (req_valid[lock_o]) w = lock_o;
        end else begin
          for (int k = 0; k < N; k++) begin
            j = (rr + k) % N;
            if (w < 0 && req_valid[j]) w = j;
          end
          if (w >= 0) rr = (w + 1) % N;
        end
        if (w >= 0) begin
          exp_ack    = N'(1) << w;
          exp_owner  = w;
          exp_init   = req_init[w];
          exp_last_n = req_last[w];
          exp_msg    = req_message[w*512 +: 512];
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
